axi4_full_slave_mem: RTL and testbench
======================================

// Module: axi4_full_slave_mem
// PURPOSE
// - AXI4-full slave memory: the downstream consumer of the M00_AXI burst master. Sits in place of the slave VIP.
// - Accepts INCR/FIXED write and read bursts into an on-chip word array. Returns OKAY or SLVERR responses.
// - Gives standalone designs a self-contained target for the master's write-then-read-compare test.
// PARAMETERS
// - C_S_AXI_DATA_WIDTH  32  data bus width in bits; must be 32 or 64.
// - C_S_AXI_ADDR_WIDTH  32  address bus width in bits.
// - C_MEM_ADDR_W        10  log2 of the number of memory words (default 1024 words).
// PORTS
// - ACLK         in   1    single clock; all logic is on the rising edge.
// - ARESETN      in   1    synchronous reset, active-low.
// - S_AXI_AWADDR  in   AW   write burst start address (byte address).
// - S_AXI_AWLEN   in   8    write beats minus 1.
// - S_AXI_AWBURST in   2    write burst type: 00 FIXED, 01 INCR, others are errors.
// - S_AXI_AWVALID in   1    write address valid.
// - S_AXI_AWREADY out  1    write address ready.
// - S_AXI_WDATA   in   DW   write data.
// - S_AXI_WSTRB   in   DW/8 byte enables.
// - S_AXI_WLAST   in   1    master's last-beat flag.
// - S_AXI_WVALID  in   1    write data valid.
// - S_AXI_WREADY  out  1    write data ready.
// - S_AXI_BRESP   out  2    write response: 00 OKAY, 10 SLVERR.
// - S_AXI_BVALID  out  1    write response valid.
// - S_AXI_BREADY  in   1    write response ready.
// - S_AXI_ARADDR  in   AW   read burst start address.
// - S_AXI_ARLEN   in   8    read beats minus 1.
// - S_AXI_ARBURST in   2    read burst type, encoded as AWBURST.
// - S_AXI_ARVALID in   1    read address valid.
// - S_AXI_ARREADY out  1    read address ready.
// - S_AXI_RDATA   out  DW   read data.
// - S_AXI_RRESP   out  2    read response: 00 OKAY, 10 SLVERR.
// - S_AXI_RLAST   out  1    asserted on beat ARLEN.
// - S_AXI_RVALID  out  1    read data valid.
// - S_AXI_RREADY  in   1    read data ready.
// BEHAVIOUR
// - Reset (ARESETN=0 at an edge): all READY, VALID and LAST outputs go to 0; BRESP, RRESP and RDATA go to 0; both FSMs go to IDLE.
//   - Memory contents are retained. A reset mid-burst abandons the burst and no response is issued.
// - Port scope: no ID, SIZE, LOCK, CACHE, PROT, QOS or USER ports. Every beat is full width. The master ties BID/RID to 0.
// - Word index = addr[ADDR_LSB +: C_MEM_ADDR_W], where ADDR_LSB = log2(DW/8). Higher address bits are ignored, so accesses alias modulo the memory size.
// - Address step per beat: INCR adds 1 to the word index, wrapping at the top of memory. FIXED does not advance.
// - Write FSM, W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: AWREADY=1. On the AW handshake, latch address, length and burst type; clear the beat counter and error flag; go to W_DATA. AWREADY=0 from the next cycle.
//   - W_DATA: WREADY=1. Each beat writes the bytes whose WSTRB bit is set. After beat AWLEN, WREADY=0 and go to W_RESP.
//   - W_DATA error flag is set when: WLAST is set on any beat other than beat AWLEN; WLAST is clear on beat AWLEN; or the burst type is 1x.
//   - A burst with burst type 1x writes nothing; its beats are still accepted.
//   - W_RESP: BVALID=1 and BRESP = flag ? 10 : 00. Both hold until BREADY; on the BVALID&&BREADY handshake go to W_IDLE.
// - Read FSM, R_IDLE -> R_DATA:
//   - R_IDLE: ARREADY=1. On the AR handshake, latch the read request.
//   - R_DATA: first RVALID one cycle after the AR handshake (registered memory read). Back-to-back beats while RREADY=1.
//   - RDATA, RRESP and RLAST hold stable while RVALID=1 and RREADY=0.
//   - After the beat-ARLEN handshake: RVALID=0, go to R_IDLE.
//   - Burst type 1x: RDATA=0 and RRESP=10 on every beat.
// - The two FSMs run independently. When a read and a write hit the same word in the same cycle, the read returns the old data.
// - AxLEN=0 gives a single-beat burst: WLAST and RLAST are on beat 0.
// CONFIGURATION
// - AXI4_SLV_RD_THROTTLE_EN defined: after every accepted R beat except the last, RVALID drops for exactly 1 cycle. Read throughput is 1 beat per 2 cycles.
// - Macro undefined: R beats are back to back with no bubbles.
// TESTING
// - Write burst: AWADDR=0x40, AWLEN=15, INCR, WDATA=1..16, WSTRB=F, WLAST on beat 15.
//   -> BRESP=00 one cycle after beat 15.
//   -> Then ARADDR=0x40, ARLEN=15 returns 1..16 with RLAST on beat 15 and RRESP=00.
// - Write 0xAABBCCDD to 0x0 with WSTRB=F, then 0x11223344 with WSTRB=0101 -> read of 0x0 returns 0xAA22CC44.
// - AWLEN=3 with WLAST set on beat 1 -> four beats accepted, BRESP=10. AWBURST=11 -> memory unchanged, BRESP=10.
// - FIXED read, ARADDR=0x8, ARLEN=3 -> four beats of mem[2]. RREADY held low 5 cycles on beat 1 -> RDATA stable throughout.
// - ARADDR=0x1000 (C_MEM_ADDR_W=10, DW=32) aliases to word 0. A 4-beat INCR burst from word 1023 returns mem[1023], mem[0], mem[1], mem[2].
// - Reset pulsed during beat 5 of a 16-beat write -> all VALID/READY = 0 next cycle, no B response, AWREADY=1 after release. Beats 0-4 are retained in memory.

Source files
------------

// File: rtl/axi4_full_slave_mem_if.sv
// AXI4-full write/read channel bundle (no ID/SIZE/LOCK/CACHE/PROT/QOS/USER) between a burst master and the slave memory.
interface axi4_full_slave_mem_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_full_slave_mem.sv
// AXI4-full slave word memory with independent INCR/FIXED write and read burst engines.
// Define AXI4_SLV_RD_THROTTLE_EN to insert a one-cycle RVALID bubble after every non-final read beat.
module axi4_full_slave_mem #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_ADDR_W       = 10
) (
  input logic ACLK,
  input logic ARESETN,
  axi4_full_slave_mem_if.slave s_axi
);
  localparam int NB       = C_S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int DEPTH    = 1 << C_MEM_ADDR_W;

  // state  | meaning
  // W_IDLE | awaiting AW    W_DATA | accepting W beats    W_RESP | holding B until BREADY
  // R_IDLE | awaiting AR    R_DATA | streaming R beats
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic [C_MEM_ADDR_W-1:0] w_idx, r_idx, r_next_idx, ar_idx;
  logic [7:0]              w_len, w_cnt, r_len, r_cnt;
  logic [1:0]              w_burst, r_burst;
  logic                    w_err, w_beat, w_last_beat, w_err_next, mem_we;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr, C_S_AXI_ADDR_WIDTH};

  assign w_beat      = (w_state == W_DATA) && s_axi.wvalid && s_axi.wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_err_next  = w_err || w_burst[1] || (s_axi.wlast != w_last_beat);
  // Reserved burst types still consume their beats but must not touch memory.
  assign mem_we      = w_beat && !w_burst[1] && ARESETN;

  assign ar_idx     = s_axi.araddr[ADDR_LSB +: C_MEM_ADDR_W];
  assign r_next_idx = (r_burst == 2'b01) ? r_idx + C_MEM_ADDR_W'(1) : r_idx;

  always_ff @(posedge ACLK) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we && s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi.awready <= 1'b1;
          if (s_axi.awvalid && s_axi.awready) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            w_idx         <= s_axi.awaddr[ADDR_LSB +: C_MEM_ADDR_W];
            w_len         <= s_axi.awlen;
            w_burst       <= s_axi.awburst;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_err <= w_err_next;
            if (w_last_beat) begin
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bresp  <= w_err_next ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              if (w_burst == 2'b01) w_idx <= w_idx + C_MEM_ADDR_W'(1);
            end
          end
        end
        W_RESP: begin
          if (s_axi.bvalid && s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // The next beat is fetched at the handshake, so a same-cycle write is seen only on later beats.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rlast   <= 1'b0;
      s_axi.rresp   <= 2'b00;
      s_axi.rdata   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi.arready <= 1'b1;
          if (s_axi.arvalid && s_axi.arready) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rlast   <= (s_axi.arlen == 8'd0);
            s_axi.rresp   <= s_axi.arburst[1] ? 2'b10 : 2'b00;
            s_axi.rdata   <= s_axi.arburst[1] ? '0 : mem[ar_idx];
            r_len         <= s_axi.arlen;
            r_burst       <= s_axi.arburst;
            r_cnt         <= '0;
            r_idx         <= ar_idx;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rvalid && s_axi.rready) begin
            if (s_axi.rlast) begin
              s_axi.rvalid  <= 1'b0;
              s_axi.rlast   <= 1'b0;
              s_axi.arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt       <= r_cnt + 8'd1;
              r_idx       <= r_next_idx;
              s_axi.rdata <= r_burst[1] ? '0 : mem[r_next_idx];
              s_axi.rlast <= (r_cnt + 8'd1 == r_len);
`ifdef AXI4_SLV_RD_THROTTLE_EN
              s_axi.rvalid <= 1'b0;
`endif
            end
          end
`ifdef AXI4_SLV_RD_THROTTLE_EN
          else if (!s_axi.rvalid) begin
            s_axi.rvalid <= 1'b1;
          end
`endif
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// Directed bench for axi4_full_slave_mem: shadow word array predicts every B and R beat checked by one monitor.
module tb_axi4_full_slave_mem;
  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  axi4_full_slave_mem_if #(.DW(32), .AW(32)) s_axi ();

  axi4_full_slave_mem #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_MEM_ADDR_W(10)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_axi(s_axi)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model_mem [1024];
  logic [31:0] last_rdata;
  logic [1:0]  last_bresp;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single compare process: every R/B handshake against the model queues, plus R hold stability.
  initial begin
    rbeat_t e;
    logic p_rv, p_rr, p_last;
    logic [31:0] p_data;
    logic [1:0] p_resp;
    p_rv = 1'b0; p_rr = 1'b0; p_last = 1'b0; p_data = '0; p_resp = '0;
    forever begin
      @(negedge ACLK);
      if (ARESETN === 1'b1) begin
        if (p_rv && !p_rr) begin
          chk("r_hold_valid", s_axi.rvalid, 1);
          chk("r_hold_data", s_axi.rdata, p_data);
          chk("r_hold_resp", s_axi.rresp, p_resp);
          chk("r_hold_last", s_axi.rlast, p_last);
        end
        if (s_axi.rvalid && s_axi.rready) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_r_beat: got %h expected none", s_axi.rdata);
          end else begin
            e = rq.pop_front();
            chk("r_data", s_axi.rdata, e.data);
            chk("r_resp", s_axi.rresp, e.resp);
            chk("r_last", s_axi.rlast, e.last);
          end
          last_rdata = s_axi.rdata;
        end
        if (s_axi.bvalid && s_axi.bready) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_b_resp: got %h expected none", s_axi.bresp);
          end else begin
            chk("b_resp", s_axi.bresp, bq.pop_front());
          end
          last_bresp = s_axi.bresp;
        end
      end
      p_rv   = (ARESETN === 1'b1) && s_axi.rvalid;
      p_rr   = s_axi.rready;
      p_data = s_axi.rdata;
      p_resp = s_axi.rresp;
      p_last = s_axi.rlast;
    end
  end

  task automatic wait_hi(input int sel, input string name);
    int n;
    logic v;
    n = 0;
    forever begin
      @(negedge ACLK);
      case (sel)
        0: v = s_axi.awready;
        1: v = s_axi.wready;
        2: v = s_axi.arready;
        default: v = s_axi.rvalid && s_axi.rready;
      endcase
      if (v === 1'b1) return;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL timeout_%s: got 0 expected 1", name);
        return;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (rq.size() != 0 || bq.size() != 0) begin
      @(posedge ACLK);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL drain_%s: got %0d pending expected 0", name, rq.size() + bq.size());
        rq.delete();
        bq.delete();
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int last_at, input logic [31:0] base, input logic [3:0] strb);
    int idx;
    logic [31:0] d;
    idx = int'((addr >> 2) & 32'h3FF);
    bq.push_back((burst[1] || last_at != len) ? 2'b10 : 2'b00);
    for (int i = 0; i <= len; i++) begin
      d = base + i;
      if (!burst[1])
        for (int b = 0; b < 4; b++) if (strb[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      if (burst == 2'b01) idx = (idx + 1) % 1024;
    end
    s_axi.awaddr = addr; s_axi.awlen = 8'(len); s_axi.awburst = burst; s_axi.awvalid = 1'b1;
    wait_hi(0, "awready");
    @(posedge ACLK); #1;
    s_axi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi.wdata = base + i; s_axi.wstrb = strb; s_axi.wlast = (i == last_at); s_axi.wvalid = 1'b1;
      wait_hi(1, "wready");
      @(posedge ACLK); #1;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    @(negedge ACLK);
    chk("bvalid_next_cycle", s_axi.bvalid, 1);
    wait_drain("write");
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input int stall_beat, input int stall_n);
    int idx;
    rbeat_t e;
    idx = int'((addr >> 2) & 32'h3FF);
    for (int i = 0; i <= len; i++) begin
      e.data = burst[1] ? 32'h0 : model_mem[idx];
      e.resp = burst[1] ? 2'b10 : 2'b00;
      e.last = (i == len);
      rq.push_back(e);
      if (burst == 2'b01) idx = (idx + 1) % 1024;
    end
    s_axi.araddr = addr; s_axi.arlen = 8'(len); s_axi.arburst = burst; s_axi.arvalid = 1'b1;
    wait_hi(2, "arready");
    @(posedge ACLK); #1;
    s_axi.arvalid = 1'b0;
    if (stall_beat > 0) begin
      for (int b = 0; b < stall_beat; b++) begin
        wait_hi(3, "r_beat");
        @(posedge ACLK); #1;
      end
      s_axi.rready = 1'b0;
      repeat (stall_n) @(posedge ACLK);
      #1;
      s_axi.rready = 1'b1;
    end
    wait_drain("read");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b1;
    s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;
    last_rdata = '0; last_bresp = '0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", s_axi.awready, 0);
    chk("rst_wready", s_axi.wready, 0);
    chk("rst_bvalid", s_axi.bvalid, 0);
    chk("rst_arready", s_axi.arready, 0);
    chk("rst_rvalid", s_axi.rvalid, 0);
    chk("rst_rlast", s_axi.rlast, 0);
    chk("rst_bresp", s_axi.bresp, 0);
    chk("rst_rresp", s_axi.rresp, 0);
    chk("rst_rdata", s_axi.rdata, 0);
    ARESETN = 1'b1;
    wait_hi(0, "awready_init");
    chk("awready_init", s_axi.awready, 1);
    @(posedge ACLK); #1;

    // 16-beat INCR write then read back
    do_write(32'h40, 15, 2'b01, 15, 32'd1, 4'hF);
    chk("model_w16", model_mem[16], 32'd1);
    chk("model_w31", model_mem[31], 32'd16);
    do_read(32'h40, 15, 2'b01, 0, 0);
    chk("incr_last_rdata", last_rdata, 32'd16);

    // byte strobes
    do_write(32'h0, 0, 2'b01, 0, 32'hAABBCCDD, 4'hF);
    do_write(32'h0, 0, 2'b01, 0, 32'h11223344, 4'h5);
    chk("model_strb", model_mem[0], 32'hAA22CC44);
    do_read(32'h0, 0, 2'b01, 0, 0);
    chk("strb_rdata", last_rdata, 32'hAA22CC44);

    // WLAST early, WLAST missing, reserved burst type
    do_write(32'h100, 3, 2'b01, 1, 32'h100, 4'hF);
    chk("bresp_early_wlast", last_bresp, 2'b10);
    do_read(32'h100, 3, 2'b01, 0, 0);
    do_write(32'h180, 1, 2'b01, -1, 32'h180, 4'hF);
    chk("bresp_no_wlast", last_bresp, 2'b10);
    do_write(32'h40, 1, 2'b11, 1, 32'hDEAD0000, 4'hF);
    chk("bresp_bad_burst", last_bresp, 2'b10);
    do_read(32'h40, 1, 2'b01, 0, 0);
    chk("bad_burst_unchanged", last_rdata, 32'd2);

    // FIXED write and FIXED read with a 5-cycle stall on beat 1
    do_write(32'h8, 2, 2'b00, 2, 32'h5A5A0000, 4'hF);
    chk("model_fixed", model_mem[2], 32'h5A5A0002);
    do_read(32'h8, 3, 2'b00, 1, 5);
    chk("fixed_rdata", last_rdata, 32'h5A5A0002);

    // reserved burst on read
    do_read(32'h40, 2, 2'b10, 0, 0);
    chk("bad_read_rdata", last_rdata, 32'h0);

    // wrap at top of memory and address aliasing
    do_write(32'hFFC, 3, 2'b01, 3, 32'hC0DE0000, 4'hF);
    chk("model_wrap", model_mem[0], 32'hC0DE0001);
    do_read(32'h1000, 0, 2'b01, 0, 0);
    chk("alias_rdata", last_rdata, 32'hC0DE0001);
    do_read(32'hFFC, 3, 2'b01, 0, 0);
    chk("wrap_rdata", last_rdata, 32'hC0DE0003);

    // reset during beat 5 of a 16-beat write
    do_write(32'h200, 15, 2'b01, 15, 32'h77770000, 4'hF);
    s_axi.awaddr = 32'h200; s_axi.awlen = 8'd15; s_axi.awburst = 2'b01; s_axi.awvalid = 1'b1;
    wait_hi(0, "awready_rst");
    @(posedge ACLK); #1;
    s_axi.awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axi.wdata = 32'h88880000 + i; s_axi.wstrb = 4'hF; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
      model_mem[128 + i] = 32'h88880000 + i;
      wait_hi(1, "wready_rst");
      @(posedge ACLK); #1;
    end
    s_axi.wdata = 32'h88880005;
    ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mid_rst_awready", s_axi.awready, 0);
    chk("mid_rst_wready", s_axi.wready, 0);
    chk("mid_rst_bvalid", s_axi.bvalid, 0);
    chk("mid_rst_arready", s_axi.arready, 0);
    chk("mid_rst_rvalid", s_axi.rvalid, 0);
    ARESETN = 1'b1;
    s_axi.wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("no_b_after_rst", s_axi.bvalid, 0);
    end
    wait_hi(0, "awready_after_rst");
    chk("awready_after_rst", s_axi.awready, 1);
    @(posedge ACLK); #1;
    chk("model_kept_beat4", model_mem[132], 32'h88880004);
    chk("model_old_beat5", model_mem[133], 32'h77770005);
    do_read(32'h200, 15, 2'b01, 0, 0);
    chk("rst_burst_tail", last_rdata, 32'h7777000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
